// File: rtl/eic_pkg.sv
// eic_pkg: shared constants and types for the eic_multi interrupt controller.
//   - register byte offsets within the EIC window
//   - bus access-size encodings
//   - arbitration FSM states
//   - CLAIM register layout
package eic_pkg;

  localparam logic [7:0] EIC_IE     = 8'h00;
  localparam logic [7:0] EIC_IP     = 8'h04;
  localparam logic [7:0] EIC_MODE   = 8'h08;
  localparam logic [7:0] EIC_POL    = 8'h0C;
  localparam logic [7:0] EIC_CLAIM  = 8'h10;
  localparam logic [7:0] EIC_SWTRIG = 8'h14;
  // First offset past the implemented registers.
  localparam logic [7:0] EIC_END    = 8'h18;

  localparam int ACC_BYTE = 0;
  localparam int ACC_HALF = 1;
  localparam int ACC_WORD = 2;

  // CLAIM: bit 31 = valid, [ID_W-1:0] = claimed source id.
  localparam int CLAIM_VLD = 31;
  localparam int ID_W      = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } eic_state_e;

endpackage

// File: rtl/eic_src_cond.sv
// eic_src_cond: conditioning for one interrupt source.
//   clk, rst : system clock, synchronous active-high reset
//   raw      : asynchronous source pin
//   pol      : 1 = active-low source (inverts the synchronised value)
//   level    : synchronised, polarity-corrected source level
//   rise     : one-cycle pulse on a 0->1 transition of level
module eic_src_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic pol,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      // History holds the post-polarity value, so the edge detector sees
      // the same signal the level path does.
      hist <= level;
    end
  end

  assign level = sync[SYNC_STAGES-1] ^ pol;
  assign rise  = level & ~hist;

endmodule

// File: rtl/eic_multi.sv
// eic_multi: parametrised external interrupt controller.
//   clk, rst          : system clock, synchronous active-high reset
//   p_*               : peripheral bus slave (req pulse in, resp pulse one
//                       cycle later with registered rdata/fault)
//   ext_int_trigger   : level interrupt request to the core
//   ext_int_handled   : one-cycle pulse, claimed interrupt serviced
//   ext_int_src_vect  : raw asynchronous interrupt sources
// Registers: IE, IP, MODE, POL, CLAIM (ro), SWTRIG (wo). Fixed priority,
// lowest index wins; the claim is frozen until the core reports handled.
module eic_multi
  import eic_pkg::*;
#(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int XLEN        = 32,
  parameter int BUS_WIDTH   = 32,
  parameter int BUS_ACC_CNT = 3,
  parameter int EIC_SIZE    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [XLEN-1:0]                p_addr,
  input  logic                           p_w_rb,
  input  logic [$clog2(BUS_ACC_CNT)-1:0] p_acc,
  output logic [BUS_WIDTH-1:0]           p_rdata,
  input  logic [BUS_WIDTH-1:0]           p_wdata,
  input  logic                           p_req,
  output logic                           p_resp,
  output logic                           p_fault,
  output logic                           ext_int_trigger,
  input  logic                           ext_int_handled,
  input  logic [N_SRC-1:0]               ext_int_src_vect
);

  localparam int AW    = $clog2(EIC_SIZE);
  localparam int ACC_W = $clog2(BUS_ACC_CNT);

  logic [N_SRC-1:0] ie, ip, ip_n, mode, pol;
  logic [N_SRC-1:0] lvl, rise, req, wd;
  logic [ID_W-1:0]  sel, claim_id;
  eic_state_e       state, state_n;

  // Source conditioning
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    eic_src_cond #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
      .clk   (clk),
      .rst   (rst),
      .raw   (ext_int_src_vect[i]),
      .pol   (pol[i]),
      .level (lvl[i]),
      .rise  (rise[i])
    );
  end

  // Bus decode
  logic [7:0]  off;
  logic        bad, wr_ok;
  logic        wr_ie, wr_ip, wr_mode, wr_pol, wr_swtrig;
  logic [31:0] rd_val, claim_word;

  assign off = 8'(p_addr[AW-1:0]);
  assign wd  = p_wdata[N_SRC-1:0];

  always_comb begin
    bad = (p_acc != ACC_W'(ACC_WORD)) || (p_addr[1:0] != 2'b00) ||
          (off >= EIC_END) ||
          (p_w_rb && off == EIC_CLAIM) ||
          (!p_w_rb && off == EIC_SWTRIG);
  end

  assign wr_ok     = p_req && p_w_rb && !bad;
  assign wr_ie     = wr_ok && off == EIC_IE;
  assign wr_ip     = wr_ok && off == EIC_IP;
  assign wr_mode   = wr_ok && off == EIC_MODE;
  assign wr_pol    = wr_ok && off == EIC_POL;
  assign wr_swtrig = wr_ok && off == EIC_SWTRIG;

  assign claim_word = (state == ARMED) ?
                      ((32'd1 << CLAIM_VLD) | 32'(claim_id)) : 32'd0;

  always_comb begin
    rd_val = 32'd0;
    case (off)
      EIC_IE:    rd_val = 32'(ie);
      EIC_IP:    rd_val = 32'(ip);
      EIC_MODE:  rd_val = 32'(mode);
      EIC_POL:   rd_val = 32'(pol);
      EIC_CLAIM: rd_val = claim_word;
      default:   rd_val = 32'd0;
    endcase
  end

  // Pending update. Level bits follow the source; edge bits are sticky with
  // set (hw edge or SWTRIG) taking priority over W1C and the DONE clear, so
  // an edge landing during DONE re-arms rather than being lost.
  always_comb begin
    ip_n = ip;
    for (int i = 0; i < N_SRC; i++) begin
      if (mode[i]) begin
        ip_n[i] = lvl[i];
      end else begin
        if (wr_ip && wd[i])                           ip_n[i] = 1'b0;
        if (state == DONE && claim_id == ID_W'(i))    ip_n[i] = 1'b0;
        if (rise[i] || (wr_swtrig && wd[i]))          ip_n[i] = 1'b1;
      end
    end
  end

  // Arbitration: lowest set index wins.
  assign req = ip & ie;

  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) sel = ID_W'(i);
    end
  end

  // FSM
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|req) state_n = ARMED;
      ARMED:   if (ext_int_handled) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign ext_int_trigger = (state == ARMED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      claim_id <= '0;
      ie       <= '0;
      ip       <= '0;
      mode     <= '0;
      pol      <= '0;
      p_resp   <= 1'b0;
      p_fault  <= 1'b0;
      p_rdata  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && |req) claim_id <= sel;
      ip <= ip_n;
      if (wr_ie)   ie   <= wd;
      if (wr_mode) mode <= wd;
      if (wr_pol)  pol  <= wd;
      p_resp  <= p_req;
      p_fault <= p_req && bad;
      p_rdata <= (p_req && !p_w_rb && !bad) ? BUS_WIDTH'(rd_val) : '0;
    end
  end

  // Address bits above the window and data bits above N_SRC are ignored.
  logic unused_bits;
  assign unused_bits = ^{p_addr, p_wdata};

endmodule

// File: tb/tb_eic_multi.sv
module tb_eic_multi;
  import eic_pkg::*;

  localparam int N_SRC = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] p_addr = '0;
  logic        p_w_rb = 1'b0;
  logic [1:0]  p_acc = 2'd2;
  logic [31:0] p_rdata;
  logic [31:0] p_wdata = '0;
  logic        p_req = 1'b0;
  logic        p_resp, p_fault, ext_int_trigger;
  logic        ext_int_handled = 1'b0;
  logic [N_SRC-1:0] ext_int_src_vect = '0;

  int n_vec = 0;
  int n_err = 0;

  eic_multi #(.N_SRC(N_SRC), .SYNC_STAGES(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .p_addr           (p_addr),
    .p_w_rb           (p_w_rb),
    .p_acc            (p_acc),
    .p_rdata          (p_rdata),
    .p_wdata          (p_wdata),
    .p_req            (p_req),
    .p_resp           (p_resp),
    .p_fault          (p_fault),
    .ext_int_trigger  (ext_int_trigger),
    .ext_int_handled  (ext_int_handled),
    .ext_int_src_vect (ext_int_src_vect)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [1:0] acc, input logic [31:0] a,
                     input logic [31:0] wdat, input logic exp_f, input logic do_rd,
                     input logic [31:0] exp_rd, input string tag);
    p_req = 1'b1; p_w_rb = w; p_acc = acc; p_addr = a; p_wdata = wdat;
    tick(1);
    p_req = 1'b0; p_w_rb = 1'b0; p_wdata = '0;
    chk({tag, ".resp"}, 32'(p_resp), 32'd1);
    chk({tag, ".fault"}, 32'(p_fault), 32'(exp_f));
    if (do_rd) chk(tag, p_rdata, exp_rd);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
    bus(1'b1, 2'd2, a, d, 1'b0, 1'b0, 32'd0, tag);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus(1'b0, 2'd2, a, 32'd0, 1'b0, 1'b1, exp, tag);
  endtask

  task automatic handled;
    ext_int_handled = 1'b1;
    tick(1);
    ext_int_handled = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick(2);
    rst = 1'b0;
    chk("rst.trig", 32'(ext_int_trigger), 32'd0);
    chk("rst.resp", 32'(p_resp), 32'd0);
    chk("rst.fault", 32'(p_fault), 32'd0);
    chk("rst.rdata", p_rdata, 32'd0);
    rd(32'h00, 32'h0, "rst.ie");
    rd(32'h04, 32'h0, "rst.ip");
    rd(32'h08, 32'h0, "rst.mode");
    rd(32'h0C, 32'h0, "rst.pol");
    rd(32'h10, 32'h0, "rst.claim");

    // Edge source 2: trigger SYNC_STAGES+2 edges after the pin goes high
    wr(32'h00, 32'h5, "t2.ie");
    ext_int_src_vect = 8'h04;
    tick(1);
    ext_int_src_vect = 8'h00;
    tick(2);
    chk("t2.trig_early", 32'(ext_int_trigger), 32'd0);
    tick(1);
    chk("t2.trig", 32'(ext_int_trigger), 32'd1);
    rd(32'h10, 32'h8000_0002, "t2.claim");
    rd(32'h04, 32'h4, "t2.ip");
    handled();
    chk("t2.trig_done", 32'(ext_int_trigger), 32'd0);
    tick(1);
    rd(32'h04, 32'h0, "t2.ip_clr");
    rd(32'h10, 32'h0, "t2.claim_clr");
    chk("t2.trig_idle", 32'(ext_int_trigger), 32'd0);

    // Sources 0 and 2 together: 0 first, then 2 re-triggers 2 cycles later
    ext_int_src_vect = 8'h05;
    tick(1);
    ext_int_src_vect = 8'h00;
    tick(3);
    chk("t3.trig", 32'(ext_int_trigger), 32'd1);
    rd(32'h10, 32'h8000_0000, "t3.claim0");
    rd(32'h04, 32'h5, "t3.ip");
    handled();
    chk("t3.trig_h1", 32'(ext_int_trigger), 32'd0);
    tick(1);
    chk("t3.trig_h2", 32'(ext_int_trigger), 32'd0);
    tick(1);
    chk("t3.retrig", 32'(ext_int_trigger), 32'd1);
    rd(32'h10, 32'h8000_0002, "t3.claim2");
    handled();
    tick(2);
    chk("t3.trig_end", 32'(ext_int_trigger), 32'd0);
    rd(32'h04, 32'h0, "t3.ip_end");

    // Level, active-low source 3
    wr(32'h08, 32'h8, "t4.mode");
    wr(32'h0C, 32'h8, "t4.pol");
    wr(32'h00, 32'h8, "t4.ie");
    tick(1);
    chk("t4.trig", 32'(ext_int_trigger), 32'd1);
    rd(32'h10, 32'h8000_0003, "t4.claim");
    rd(32'h04, 32'h8, "t4.ip");
    handled();
    chk("t4.trig_h1", 32'(ext_int_trigger), 32'd0);
    tick(1);
    chk("t4.trig_h2", 32'(ext_int_trigger), 32'd0);
    tick(1);
    chk("t4.retrig", 32'(ext_int_trigger), 32'd1);
    ext_int_src_vect = 8'h08;
    tick(3);
    rd(32'h04, 32'h0, "t4.ip_idle");
    handled();
    tick(4);
    chk("t4.no_retrig", 32'(ext_int_trigger), 32'd0);
    // Back to edge/active-high without a spurious edge
    wr(32'h00, 32'h0, "t4.ie_off");
    ext_int_src_vect = 8'h00;
    tick(3);
    wr(32'h0C, 32'h0, "t4.pol_off");
    wr(32'h08, 32'h0, "t4.mode_off");
    rd(32'h04, 32'h0, "t4.ip_restored");

    // Software trigger and W1C
    wr(32'h00, 32'h10, "t5.ie");
    wr(32'h14, 32'h10, "t5.swtrig");
    chk("t5.trig_early", 32'(ext_int_trigger), 32'd0);
    tick(1);
    chk("t5.trig", 32'(ext_int_trigger), 32'd1);
    rd(32'h10, 32'h8000_0004, "t5.claim");
    rd(32'h04, 32'h10, "t5.ip");
    handled();
    tick(1);
    rd(32'h04, 32'h0, "t5.ip_done");
    wr(32'h00, 32'h0, "t5.ie_off");
    wr(32'h14, 32'h10, "t5.swtrig2");
    rd(32'h04, 32'h10, "t5.ip_sw");
    chk("t5.no_trig", 32'(ext_int_trigger), 32'd0);
    wr(32'h04, 32'h10, "t5.w1c");
    rd(32'h04, 32'h0, "t5.ip_w1c");

    // Faults, no side effects; bits above N_SRC read 0
    wr(32'h00, 32'hFFFF_FFA0, "t6.ie");
    rd(32'h00, 32'hA0, "t6.ie_rd");
    bus(1'b0, 2'd0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h0, "t6.byte_rd");
    bus(1'b0, 2'd2, 32'h02, 32'h0, 1'b1, 1'b0, 32'h0, "t6.misalign");
    bus(1'b0, 2'd2, 32'h18, 32'h0, 1'b1, 1'b0, 32'h0, "t6.oor_rd");
    bus(1'b1, 2'd2, 32'h10, 32'hFF, 1'b1, 1'b0, 32'h0, "t6.claim_wr");
    bus(1'b0, 2'd2, 32'h14, 32'h0, 1'b1, 1'b0, 32'h0, "t6.swtrig_rd");
    bus(1'b1, 2'd0, 32'h00, 32'hFF, 1'b1, 1'b0, 32'h0, "t6.byte_wr");
    bus(1'b1, 2'd2, 32'h1C, 32'hFF, 1'b1, 1'b0, 32'h0, "t6.oor_wr");
    rd(32'h00, 32'hA0, "t6.ie_kept");
    rd(32'h04, 32'h0, "t6.ip_kept");
    handled();
    tick(1);
    chk("t6.idle_handled", 32'(ext_int_trigger), 32'd0);
    rd(32'h10, 32'h0, "t6.claim_idle");

    // Reset in the middle of a handshake
    wr(32'h00, 32'h2, "t7.ie");
    wr(32'h14, 32'h2, "t7.swtrig");
    tick(1);
    chk("t7.trig", 32'(ext_int_trigger), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t7.trig_rst", 32'(ext_int_trigger), 32'd0);
    handled();
    tick(1);
    chk("t7.trig_after", 32'(ext_int_trigger), 32'd0);
    rd(32'h00, 32'h0, "t7.ie_rst");
    rd(32'h10, 32'h0, "t7.claim_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eic_multi.md
Name: eic_multi

Overview:
- Parametrised external interrupt controller, successor to the fixed-configuration EIC on the platform peripheral bus.
- Accepts N_SRC asynchronous interrupt sources.
  - Each source is configurable as edge or level, with selectable polarity.
  - Each source has enable, pending and software-trigger bits.
- Fixed-priority arbitration, lowest index wins. Arbitrated result drives a single trigger/handled handshake to the core, with a readable claim register.
- Bus-attached via the standard p_* slave protocol; occupies EIC_SIZE bytes.

Parameters:
- N_SRC, 8: number of interrupt sources, 1..32.
- SYNC_STAGES, 2: input synchroniser depth, >=2.
- XLEN, 32: bus address width.
- BUS_WIDTH, 32: bus data width.
- BUS_ACC_CNT, 3: number of access-size encodings (0 byte, 1 half, 2 word).
- EIC_SIZE, 32: register window in bytes; decoded address width is $clog2(EIC_SIZE).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- p_addr  in  XLEN  byte address; only low $clog2(EIC_SIZE) bits decoded
- p_w_rb  in  1  1 = write, 0 = read
- p_acc  in  $clog2(BUS_ACC_CNT)  access size
- p_rdata  out  BUS_WIDTH  read data, valid with p_resp
- p_wdata  in  BUS_WIDTH  write data
- p_req  in  1  single-cycle request pulse
- p_resp  out  1  single-cycle response pulse
- p_fault  out  1  error flag, valid with p_resp
- ext_int_trigger  out  1  interrupt request to core, level
- ext_int_handled  in  1  single-cycle pulse from core: claimed interrupt serviced
- ext_int_src_vect  in  N_SRC  raw asynchronous sources

Behaviour:
- Reset values:
  - Registers IE, IP, MODE and POL are 0.
  - The FSM is in IDLE.
  - Outputs p_resp, p_fault, p_rdata and ext_int_trigger are 0.
  - Synchroniser and edge-history flops are 0.
- Reset mid-handshake:
  - The claim is dropped and the trigger is 0 after the reset edge.
  - A later ext_int_handled is ignored.
- Source conditioning, per source i:
  - SYNC_STAGES flops, then a history flop.
  - Polarity: s = sync ^ POL[i].
  - Edge mode (MODE[i]=0): a rising edge of s sets IP[i].
  - Level mode (MODE[i]=1): IP[i] = s, live, not sticky.
  - Latency from source pin to IP set is SYNC_STAGES+1 cycles.
- Register map (word offsets). Only p_acc=2 with addr[1:0]=0 is legal; anything else faults.
  - 0x00 IE: rw.
  - 0x04 IP:
    - Read returns live pending.
    - Write-1-to-clear applies to edge bits only; level bits ignore writes.
  - 0x08 MODE: rw.
  - 0x0C POL: rw.
  - 0x10 CLAIM: ro.
    - Bit 31 is valid; bits [4:0] hold the claimed id.
    - Reads return 0 when no claim is active.
  - 0x14 SWTRIG: wo. Writing 1 sets IP for edge-mode bits; level-mode bits are ignored.
  - Bits at and above N_SRC read 0 and ignore writes.
- Bus timing: p_resp is asserted exactly 1 cycle after p_req; p_rdata is registered.
- p_fault=1 (no register side effect) on any of:
  - illegal size or alignment;
  - offset at or above 0x18;
  - write to CLAIM;
  - read of SWTRIG.
- Simultaneous events:
  - Hardware edge and W1C on the same bit in the same cycle: set wins.
  - SWTRIG and W1C on the same bit cannot coincide, since they are different addresses.
- Arbitration: req = IP & IE. sel = lowest set index of req.
- FSM:
  - IDLE: if |req, latch sel into claim_id and go to ARMED.
  - ARMED: ext_int_trigger=1 and CLAIM is valid. On ext_int_handled, go to DONE.
  - DONE: one cycle, trigger=0.
    - If the claimed source is in edge mode, clear IP[claim_id].
    - Then go to IDLE, where arbitration resamples. A still-active level source re-triggers 2 cycles after handled.
- Trigger latency: first cycle with |req in IDLE, then trigger high on the next cycle.
- claim_id is frozen while ARMED. A higher-priority arrival does not preempt it; it is arbitrated after DONE.
- If IE[claim_id] is cleared while ARMED, the trigger stays high until handled. Software must still complete.
- ext_int_handled is ignored in IDLE and DONE.
- Edge re-arm: a new edge arriving on the claimed source during DONE sets IP, because set wins over the DONE clear. That interrupt is not lost.

Decomposition:
- Package eic_pkg holds:
  - register offsets (EIC_IE, EIC_IP, EIC_MODE, EIC_POL, EIC_CLAIM, EIC_SWTRIG);
  - access-size encodings (ACC_BYTE/HALF/WORD);
  - FSM state enum (IDLE, ARMED, DONE);
  - CLAIM valid-bit index.
- Sub-module eic_src_cond: per-source synchroniser, polarity and edge detect. Inputs: clk, rst, raw, pol. Outputs: level, rise. Instantiated N_SRC times in a generate loop.
- Top level holds the registers, priority encoder, FSM and bus slave.

Test Plan:
- Reset then read all registers -> IE/IP/MODE/POL/CLAIM = 0, p_fault=0, p_resp 1 cycle after each p_req.
- IE=0x0000_0005, edge mode; pulse src[2] -> ext_int_trigger rises SYNC_STAGES+2 cycles later, CLAIM=0x8000_0002; pulse handled -> trigger 0, IP[2]=0, CLAIM=0.
- Pulse src[0] and src[2] in the same cycle -> claim id 0 first; after handled, trigger re-rises 2 cycles later with CLAIM=0x8000_0002.
- MODE[3]=1, POL[3]=1, IE[3]=1; hold src[3] low -> trigger; handled while still low -> trigger re-asserts 2 cycles later; drive high -> IP[3]=0 and no further trigger.
- Write SWTRIG=0x10 with IE[4]=1 -> IP=0x10 and trigger; write IP=0x10 in IDLE with IE[4]=0 -> IP cleared.
- Byte read of 0x00, word read at 0x02, read of 0x18, write to 0x10 -> each gives p_fault=1 with registers unchanged; handled pulse in IDLE -> no state change.
